// File: rtl/logic_chk_pkg.sv
// Shared types and constants for the logic-gate result checker.
package logic_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned NUM_OUTS = 5;

    localparam int unsigned MSK_AND  = 0;
    localparam int unsigned MSK_OR   = 1;
    localparam int unsigned MSK_XOR  = 2;
    localparam int unsigned MSK_NAND = 3;
    localparam int unsigned MSK_NOR  = 4;

endpackage

// File: rtl/logic_ref_model.sv
// Combinational golden model of the gate stage: the five expected words for a and b.
module logic_ref_model #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y_and,
    output logic [WIDTH-1:0] y_or,
    output logic [WIDTH-1:0] y_xor,
    output logic [WIDTH-1:0] y_nand,
    output logic [WIDTH-1:0] y_nor
);

    assign y_and  = a & b;
    assign y_or   = a | b;
    assign y_xor  = a ^ b;
    assign y_nand = ~(a & b);
    assign y_nor  = ~(a | b);

endmodule

// File: rtl/logic_result_checker.sv
// Checks gate-stage samples against the reference model over a fixed-length run,
// counting passes/fails and capturing the first failing sample.
module logic_result_checker
    import logic_chk_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned NUM_SAMPLES = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sample_valid,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [WIDTH-1:0]    y1,
    input  logic [WIDTH-1:0]    y2,
    input  logic [WIDTH-1:0]    y3,
    input  logic [WIDTH-1:0]    y4,
    input  logic [WIDTH-1:0]    y5,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    pass_count,
    output logic [CNT_W-1:0]    fail_count,
    output logic                err_flag,
    output logic [CNT_W-1:0]    first_fail_idx,
    output logic [NUM_OUTS-1:0] first_fail_mask
);

    localparam int unsigned AW = $clog2(NUM_SAMPLES + 1);
    localparam logic [AW-1:0] LAST_ACC = AW'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e state_q, state_d;
    logic   accept, run_clear;

    logic [AW-1:0]    acc_q;
    logic [CNT_W-1:0] idx_q;

    logic                            s1_valid_q;
    logic [WIDTH-1:0]                s1_a_q, s1_b_q;
    logic [NUM_OUTS-1:0][WIDTH-1:0]  s1_y_q;
    logic [CNT_W-1:0]                s1_idx_q;

    logic                s2_valid_q;
    logic [NUM_OUTS-1:0] s2_mask_q, mask_d;
    logic [CNT_W-1:0]    s2_idx_q;

    logic [WIDTH-1:0] e_and, e_or, e_xor, e_nand, e_nor;

    logic_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .y_and  (e_and),
        .y_or   (e_or),
        .y_xor  (e_xor),
        .y_nand (e_nand),
        .y_nor  (e_nor)
    );

    always_comb begin
        mask_d           = '0;
        mask_d[MSK_AND]  = s1_y_q[0] != e_and;
        mask_d[MSK_OR]   = s1_y_q[1] != e_or;
        mask_d[MSK_XOR]  = s1_y_q[2] != e_xor;
        mask_d[MSK_NAND] = s1_y_q[3] != e_nand;
        mask_d[MSK_NOR]  = s1_y_q[4] != e_nor;
    end

    // DRAIN leaves once stage 1 is empty; stage 2 retires on that same edge.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        run_clear = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    run_clear = 1'b1;
                end
            end
            RUN: begin
                if (sample_valid) begin
                    accept = 1'b1;
                    if (acc_q == LAST_ACC) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            acc_q           <= '0;
            idx_q           <= '0;
            s1_valid_q      <= 1'b0;
            s2_valid_q      <= 1'b0;
            pass_count      <= '0;
            fail_count      <= '0;
            err_flag        <= 1'b0;
            first_fail_idx  <= '0;
            first_fail_mask <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
            if (run_clear) begin
                acc_q <= '0;
                idx_q <= '0;
            end else if (accept) begin
                acc_q <= acc_q + AW'(1);
                idx_q <= idx_q + CNT_W'(1);
            end
            if (run_clear) begin
                pass_count      <= '0;
                fail_count      <= '0;
                err_flag        <= 1'b0;
                first_fail_idx  <= '0;
                first_fail_mask <= '0;
            end else if (s2_valid_q) begin
                if (s2_mask_q == '0) begin
                    if (pass_count != CNT_MAX) pass_count <= pass_count + CNT_W'(1);
                end else begin
                    if (fail_count != CNT_MAX) fail_count <= fail_count + CNT_W'(1);
                    if (!err_flag) begin
                        err_flag        <= 1'b1;
                        first_fail_idx  <= s2_idx_q;
                        first_fail_mask <= s2_mask_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a_q   <= a;
            s1_b_q   <= b;
            s1_y_q   <= {y5, y4, y3, y2, y1};
            s1_idx_q <= idx_q;
        end
        if (s1_valid_q) begin
            s2_mask_q <= mask_d;
            s2_idx_q  <= s1_idx_q;
        end
    end

    assign busy = (state_q == RUN) || (state_q == DRAIN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_logic_result_checker.sv
// Directed/randomized bench for logic_result_checker with a behavioural scoreboard.
module tb_logic_result_checker;

    localparam int WIDTH = 4;
    localparam int NSAMP = 16;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, sample_valid;
    logic [WIDTH-1:0] a, b, y1, y2, y3, y4, y5;
    logic             busy, done, err_flag;
    logic [CNT_W-1:0] pass_count, fail_count, first_fail_idx;
    logic [4:0]       first_fail_mask;

    logic_result_checker #(.WIDTH(WIDTH), .NUM_SAMPLES(NSAMP), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .sample_valid    (sample_valid),
        .a               (a),
        .b               (b),
        .y1              (y1),
        .y2              (y2),
        .y3              (y3),
        .y4              (y4),
        .y5              (y5),
        .busy            (busy),
        .done            (done),
        .pass_count      (pass_count),
        .fail_count      (fail_count),
        .err_flag        (err_flag),
        .first_fail_idx  (first_fail_idx),
        .first_fail_mask (first_fail_mask)
    );

    int compared   = 0;
    int mismatched = 0;

    int         exp_pass, exp_fail, n_acc;
    logic       exp_err;
    logic [7:0] exp_idx;
    logic [4:0] exp_mask;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_pass = 0;
        exp_fail = 0;
        n_acc    = 0;
        exp_err  = 1'b0;
        exp_idx  = '0;
        exp_mask = '0;
    endtask

    task automatic model_accept(input logic [4:0] m);
        if (m != 5'd0) begin
            if (!exp_err) begin
                exp_err  = 1'b1;
                exp_idx  = 8'(n_acc % 256);
                exp_mask = m;
            end
            if (exp_fail < 255) exp_fail++;
        end else if (exp_pass < 255) begin
            exp_pass++;
        end
        n_acc++;
    endtask

    task automatic send_raw(input logic [3:0] va, vb, v1, v2, v3, v4, v5, input bit counted);
        logic [3:0] ea, eo, ex, en, er;
        logic [4:0] m;
        ea = va & vb;
        eo = va | vb;
        ex = va ^ vb;
        en = ~ea;
        er = ~eo;
        m  = {v5 != er, v4 != en, v3 != ex, v2 != eo, v1 != ea};
        a = va; b = vb; y1 = v1; y2 = v2; y3 = v3; y4 = v4; y5 = v5;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        if (counted) model_accept(m);
    endtask

    // Random operands; outputs selected by fm are corrupted with a nonzero XOR.
    task automatic send_rand(input logic [4:0] fm, input bit counted);
        logic [3:0] va, vb;
        logic [3:0] v [5];
        va   = 4'($urandom_range(0, 15));
        vb   = 4'($urandom_range(0, 15));
        v[0] = va & vb;
        v[1] = va | vb;
        v[2] = va ^ vb;
        v[3] = ~(va & vb);
        v[4] = ~(va | vb);
        for (int k = 0; k < 5; k++)
            if (fm[k]) v[k] = v[k] ^ 4'($urandom_range(1, 15));
        send_raw(va, vb, v[0], v[1], v[2], v[3], v[4], counted);
    endtask

    function automatic logic [4:0] rand_fault();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
    endfunction

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    task automatic check_results(input string tag);
        check({tag, "_pass"}, 32'(pass_count), 32'(exp_pass));
        check({tag, "_fail"}, 32'(fail_count), 32'(exp_fail));
        check({tag, "_err"}, 32'(err_flag), 32'(exp_err));
        check({tag, "_fidx"}, 32'(first_fail_idx), 32'(exp_idx));
        check({tag, "_fmask"}, 32'(first_fail_mask), 32'(exp_mask));
    endtask

    task automatic finish_run(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check_results(tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sample_valid = 1'b0;
        a = '0; b = '0; y1 = '0; y2 = '0; y3 = '0; y4 = '0; y5 = '0;
        model_clear();

        // Reset, then samples in IDLE must be ignored
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_results("rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send_rand(5'd0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("idle_busy", 32'(busy), 32'd0);
        check_results("idle");

        // Clean back-to-back run with exact completion timing
        start_run();
        check("clean_busy0", 32'(busy), 32'd1);
        for (int i = 0; i < NSAMP; i++) send_rand(5'd0, 1'b1);
        check("clean_busy_e0", 32'(busy), 32'd1);
        tick();
        check("clean_busy_e1", 32'(busy), 32'd1);
        check("clean_done_e1", 32'(done), 32'd0);
        tick();
        check("clean_busy_e2", 32'(busy), 32'd0);
        check("clean_done_e2", 32'(done), 32'd1);
        check_results("clean");
        check("clean_pass16", 32'(pass_count), 32'd16);

        // Injected faults at idx 5 (y3) and idx 9 (y5); start from DONE
        start_run();
        check("inj_done_clr", 32'(done), 32'd0);
        check("inj_pass_clr", 32'(pass_count), 32'd0);
        for (int i = 0; i < NSAMP; i++) begin
            if (i == 5) send_raw(4'b1110, 4'b1000, 4'b1000, 4'b1110, 4'b0000, 4'b0111,
                                 4'b0001, 1'b1);
            else if (i == 9) send_rand(5'b10000, 1'b1);
            else send_rand(5'd0, 1'b1);
        end
        finish_run("inj");
        check("inj_fail2", 32'(fail_count), 32'd2);
        check("inj_pass14", 32'(pass_count), 32'd14);
        check("inj_idx5", 32'(first_fail_idx), 32'd5);
        check("inj_mask", 32'(first_fail_mask), 32'b00100);

        // Gapped valid with an ignored start mid-run
        start_run();
        for (int i = 0; i < NSAMP; i++) begin
            send_rand(rand_fault(), 1'b1);
            if (i == 7) start = 1'b1;
            tick();
            start = 1'b0;
            tick();
        end
        finish_run("gap");

        // Reset mid-run discards everything
        start_run();
        for (int i = 0; i < 7; i++) send_rand(rand_fault(), 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check_results("mrst");
        start_run();
        for (int i = 0; i < NSAMP; i++) send_rand(rand_fault(), 1'b1);
        finish_run("post_rst");

        // Restart from DONE with every sample failing
        start_run();
        check("rs_done_clr", 32'(done), 32'd0);
        check("rs_busy", 32'(busy), 32'd1);
        check("rs_fail_clr", 32'(fail_count), 32'd0);
        check("rs_err_clr", 32'(err_flag), 32'd0);
        for (int i = 0; i < NSAMP; i++) send_rand(5'($urandom_range(1, 31)), 1'b1);
        finish_run("allfail");
        check("allfail_16", 32'(fail_count), 32'd16);
        check("allfail_idx0", 32'(first_fail_idx), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
